// File: rtl/mem_stage_if.sv
// Signal bundle around the MEM stage: EX payload, data_sram response, WB handshake
// and the forwarding/stall outputs toward ID and EX.
interface mem_stage_if #(
  parameter int SIDE_W = 120
);
  logic              ex_to_mem_valid;
  logic              mem_allowin;
  logic [31:0]       ex_pc;
  logic              ex_rf_we;
  logic [4:0]        ex_rf_waddr;
  logic [31:0]       ex_result;
  logic [4:0]        ex_ld_op;
  logic              ex_req_sent;
  logic              ex_excep;
  logic [SIDE_W-1:0] ex_side;
  logic              data_sram_data_ok;
  logic [31:0]       data_sram_rdata;
  logic              flush;
  logic              wb_allowin;
  logic              mem_to_wb_valid;
  logic [31:0]       mem_pc;
  logic              mem_rf_we;
  logic [4:0]        mem_rf_waddr;
  logic [31:0]       mem_rf_wdata;
  logic              mem_excep;
  logic [SIDE_W-1:0] mem_side;
  logic              mem_fwd_we;
  logic [4:0]        mem_fwd_waddr;
  logic [31:0]       mem_fwd_wdata;
  logic              mem_fwd_stall;
  logic              mem_excep_active;

  modport slave (
    input  ex_to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_ld_op,
           ex_req_sent, ex_excep, ex_side, data_sram_data_ok, data_sram_rdata,
           flush, wb_allowin,
    output mem_allowin, mem_to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr,
           mem_rf_wdata, mem_excep, mem_side, mem_fwd_we, mem_fwd_waddr,
           mem_fwd_wdata, mem_fwd_stall, mem_excep_active
  );

  modport master (
    output ex_to_mem_valid, ex_pc, ex_rf_we, ex_rf_waddr, ex_result, ex_ld_op,
           ex_req_sent, ex_excep, ex_side, data_sram_data_ok, data_sram_rdata,
           flush, wb_allowin,
    input  mem_allowin, mem_to_wb_valid, mem_pc, mem_rf_we, mem_rf_waddr,
           mem_rf_wdata, mem_excep, mem_side, mem_fwd_we, mem_fwd_waddr,
           mem_fwd_wdata, mem_fwd_stall, mem_excep_active
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: waits for the data_sram response of the resident instruction,
// extends load data, forwards to ID and hands off to WB; drops responses of flushed work.
module mem_stage #(
  parameter int SIDE_W = 120
) (
  input  logic       clk,
  input  logic       resetn,
  mem_stage_if.slave bus
);
  typedef struct packed {
    logic [31:0]       pc;
    logic              rf_we;
    logic [4:0]        rf_waddr;
    logic [31:0]       result;
    logic [4:0]        ld_op;   // {w,hu,h,bu,b}
    logic              excep;
    logic [SIDE_W-1:0] side;
  } payload_t;

  logic        mem_valid_q, mem_valid_d;
  logic        waiting_q, waiting_d;
  logic        got_data_q, got_data_d;
  logic [1:0]  cancel_cnt_q, cancel_cnt_d;
  logic [31:0] rdata_buf_q, rdata_buf_d;
  payload_t    pl_q, pl_d;

  logic        resp_hit, ready_go, allowin, accept, pending;
  logic [2:0]  cancel_sum;
  logic [31:0] ld_word, wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // A response satisfies the resident instruction only once all stale ones are drained.
  assign resp_hit = bus.data_sram_data_ok & (cancel_cnt_q == 2'd0);
  assign ready_go = ~waiting_q | got_data_q | resp_hit;
  assign allowin  = ~mem_valid_q | (ready_go & bus.wb_allowin);
  assign accept   = bus.ex_to_mem_valid & allowin & ~bus.flush;
  assign pending  = mem_valid_q & waiting_q & ~got_data_q & ~resp_hit;

  always_comb begin
    // NOTE: every _d gets its default first so no branch can infer a latch.
    mem_valid_d = mem_valid_q;
    waiting_d   = waiting_q;
    got_data_d  = got_data_q;
    rdata_buf_d = rdata_buf_q;
    pl_d        = pl_q;

    cancel_sum = {1'b0, cancel_cnt_q}
               - {2'b00, bus.data_sram_data_ok & (cancel_cnt_q != 2'd0)};
    if (bus.flush) begin
      cancel_sum = cancel_sum + {2'b00, pending}
                 + {2'b00, bus.ex_to_mem_valid & bus.ex_req_sent};
    end
    cancel_cnt_d = (cancel_sum > 3'd3) ? 2'd3 : cancel_sum[1:0];

    if (waiting_q & ~got_data_q & resp_hit) begin
      got_data_d  = 1'b1;
      rdata_buf_d = bus.data_sram_rdata;
    end

    if (accept) begin
      mem_valid_d = 1'b1;
      waiting_d   = bus.ex_req_sent;
      got_data_d  = 1'b0;
      pl_d.pc       = bus.ex_pc;
      pl_d.rf_we    = bus.ex_rf_we;
      pl_d.rf_waddr = bus.ex_rf_waddr;
      pl_d.result   = bus.ex_result;
      pl_d.ld_op    = bus.ex_ld_op;
      pl_d.excep    = bus.ex_excep;
      pl_d.side     = bus.ex_side;
    end else if (bus.flush | allowin) begin
      mem_valid_d = 1'b0;
      waiting_d   = 1'b0;
      got_data_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state uses non-blocking assignments; the async reset clears every flop, load buffer included.
    if (!resetn) begin
      mem_valid_q  <= 1'b0;
      waiting_q    <= 1'b0;
      got_data_q   <= 1'b0;
      cancel_cnt_q <= 2'd0;
      rdata_buf_q  <= 32'd0;
      pl_q         <= '0;
    end else begin
      mem_valid_q  <= mem_valid_d;
      waiting_q    <= waiting_d;
      got_data_q   <= got_data_d;
      cancel_cnt_q <= cancel_cnt_d;
      rdata_buf_q  <= rdata_buf_d;
      pl_q         <= pl_d;
    end
  end

  // Once buffered, the load word comes from the buffer, otherwise straight off the bus.
  assign ld_word = got_data_q ? rdata_buf_q : bus.data_sram_rdata;
  assign ld_half = pl_q.result[1] ? ld_word[31:16] : ld_word[15:0];

  always_comb begin
    case (pl_q.result[1:0])
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase

    if (pl_q.ld_op[4])      wdata = ld_word;
    else if (pl_q.ld_op[3]) wdata = {16'd0, ld_half};
    else if (pl_q.ld_op[2]) wdata = {{16{ld_half[15]}}, ld_half};
    else if (pl_q.ld_op[1]) wdata = {24'd0, ld_byte};
    else if (pl_q.ld_op[0]) wdata = {{24{ld_byte[7]}}, ld_byte};
    else                    wdata = pl_q.result;
  end

  assign bus.mem_allowin      = allowin;
  assign bus.mem_to_wb_valid  = mem_valid_q & ready_go & ~bus.flush;
  assign bus.mem_pc           = pl_q.pc;
  assign bus.mem_rf_we        = pl_q.rf_we;
  assign bus.mem_rf_waddr     = pl_q.rf_waddr;
  assign bus.mem_rf_wdata     = wdata;
  assign bus.mem_excep        = pl_q.excep;
  assign bus.mem_side         = pl_q.side;
  assign bus.mem_fwd_we       = mem_valid_q & pl_q.rf_we & ~pl_q.excep;
  assign bus.mem_fwd_waddr    = pl_q.rf_waddr;
  assign bus.mem_fwd_wdata    = wdata;
  assign bus.mem_fwd_stall    = mem_valid_q & (|pl_q.ld_op) & ~got_data_q & ~resp_hit;
  assign bus.mem_excep_active = mem_valid_q & pl_q.excep;
endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: extraction vector table, hand-written corner
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_stage;
  localparam int SIDE_W = 120;
  localparam logic [4:0] LD_B  = 5'b00001;
  localparam logic [4:0] LD_BU = 5'b00010;
  localparam logic [4:0] LD_H  = 5'b00100;
  localparam logic [4:0] LD_HU = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b10000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if #(.SIDE_W(SIDE_W)) bus ();
  mem_stage #(.SIDE_W(SIDE_W)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[11];

  typedef struct {
    logic        v;
    int          id;
    logic [31:0] pc;
    logic [4:0]  op;
    logic [31:0] addr;
    logic        needs;
    logic        rcvd;
    logic [31:0] data;
    logic        excep;
    logic        we;
  } occ_t;
  typedef struct {
    int id;
    int issued;
  } rsp_t;

  occ_t occ, nw;
  rsp_t rq[$];
  rsp_t rtmp;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [SIDE_W-1:0] side_of(input logic [31:0] pc);
    return {24'hA5C3E1, pc, ~pc, pc ^ 32'h5A5A_5A5A};
  endfunction

  // Reference extraction: pick the addressed byte/halfword arithmetically, then extend.
  function automatic logic [31:0] ref_wdata(input logic [4:0] op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
    int unsigned b, h;
    int s;
    b = (rdata >> (8 * int'(addr[1:0]))) & 32'hFF;
    h = (rdata >> (16 * int'(addr[1]))) & 32'hFFFF;
    case (op)
      LD_B:    s = (b >= 128) ? int'(b) - 256 : int'(b);
      LD_BU:   s = int'(b);
      LD_H:    s = (h >= 32768) ? int'(h) - 65536 : int'(h);
      LD_HU:   s = int'(h);
      LD_W:    s = int'(rdata);
      default: s = int'(addr);
    endcase
    return 32'(s);
  endfunction

  task automatic set_idle();
    bus.ex_to_mem_valid   = 1'b0;
    bus.ex_pc             = 32'd0;
    bus.ex_rf_we          = 1'b0;
    bus.ex_rf_waddr       = 5'd0;
    bus.ex_result         = 32'd0;
    bus.ex_ld_op          = 5'd0;
    bus.ex_req_sent       = 1'b0;
    bus.ex_excep          = 1'b0;
    bus.ex_side           = '0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = $urandom();
    bus.flush             = 1'b0;
    bus.wb_allowin        = 1'b1;
  endtask

  task automatic present(input logic [4:0] op, input logic [31:0] addr, input logic req,
                         input logic excep, input logic we, input logic [4:0] waddr,
                         input logic [31:0] pc);
    bus.ex_to_mem_valid = 1'b1;
    bus.ex_pc           = pc;
    bus.ex_rf_we        = we;
    bus.ex_rf_waddr     = waddr;
    bus.ex_result       = addr;
    bus.ex_ld_op        = op;
    bus.ex_req_sent     = req;
    bus.ex_excep        = excep;
    bus.ex_side         = side_of(pc);
  endtask

  task automatic cyc_start();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #3;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " allowin"},      bus.mem_allowin, 1);
    check({tag, " to_wb_valid"},  bus.mem_to_wb_valid, 0);
    check({tag, " pc"},           bus.mem_pc, 0);
    check({tag, " rf_we"},        bus.mem_rf_we, 0);
    check({tag, " rf_waddr"},     bus.mem_rf_waddr, 0);
    check({tag, " rf_wdata"},     bus.mem_rf_wdata, 0);
    check({tag, " excep"},        bus.mem_excep, 0);
    check({tag, " side"},         bus.mem_side, 0);
    check({tag, " fwd_we"},       bus.mem_fwd_we, 0);
    check({tag, " fwd_waddr"},    bus.mem_fwd_waddr, 0);
    check({tag, " fwd_wdata"},    bus.mem_fwd_wdata, 0);
    check({tag, " fwd_stall"},    bus.mem_fwd_stall, 0);
    check({tag, " excep_active"}, bus.mem_excep_active, 0);
  endtask

  logic        deliver, hit, have, e_ready, e_valid, e_allowin, e_stall, pres;
  logic [31:0] word, e_wdata;
  int          d_id, stale, nid, kind;

  initial begin
    vecs[0]  = '{LD_B,  32'h0000_1003, 32'h80FF_1234, 32'hFFFF_FF80};
    vecs[1]  = '{LD_BU, 32'h0000_1003, 32'h80FF_1234, 32'h0000_0080};
    vecs[2]  = '{LD_B,  32'h0000_1000, 32'h80FF_1234, 32'h0000_0034};
    vecs[3]  = '{LD_BU, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012};
    vecs[4]  = '{LD_B,  32'h0000_1002, 32'h80FF_1234, 32'hFFFF_FFFF};
    vecs[5]  = '{LD_HU, 32'h0000_2002, 32'h9ABC_0000, 32'h0000_9ABC};
    vecs[6]  = '{LD_H,  32'h0000_2002, 32'h9ABC_0000, 32'hFFFF_9ABC};
    vecs[7]  = '{LD_H,  32'h0000_2000, 32'h0000_8001, 32'hFFFF_8001};
    vecs[8]  = '{LD_HU, 32'h0000_2000, 32'h0000_8001, 32'h0000_8001};
    vecs[9]  = '{LD_W,  32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[10] = '{5'd0,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678};

    set_idle();
    resetn = 1'b0;
    #12;
    check_reset("reset");
    @(posedge clk);
    #1 resetn = 1'b1;

    // Extraction table: accept, then the response (if any) in the next cycle.
    foreach (vecs[i]) begin
      cyc_start(); set_idle();
      present(vecs[i].op, vecs[i].addr, vecs[i].op != 5'd0, 1'b0, 1'b1, 5'(i + 1),
              32'h1C00_0000 + 32'(4 * i));
      sample();
      check("tbl allowin", bus.mem_allowin, 1);
      cyc_start(); set_idle();
      if (vecs[i].op != 5'd0) begin
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = vecs[i].rdata;
      end
      sample();
      check("tbl to_wb_valid", bus.mem_to_wb_valid, 1);
      check("tbl rf_wdata",    bus.mem_rf_wdata, vecs[i].exp);
      check("tbl fwd_wdata",   bus.mem_fwd_wdata, vecs[i].exp);
      check("tbl fwd_we",      bus.mem_fwd_we, 1);
      check("tbl side",        bus.mem_side, side_of(32'h1C00_0000 + 32'(4 * i)));
    end
    cyc_start(); set_idle(); sample();
    check("tbl drained", bus.mem_to_wb_valid, 0);

    // ld.b with a two-cycle response latency.
    cyc_start(); set_idle();
    present(LD_B, 32'h0000_4003, 1'b1, 1'b0, 1'b1, 5'd7, 32'h1C00_1000);
    sample();
    repeat (2) begin
      cyc_start(); set_idle(); sample();
      check("ldb stall", bus.mem_fwd_stall, 1);
      check("ldb hold", bus.mem_to_wb_valid, 0);
    end
    cyc_start(); set_idle();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h80FF_1234;
    sample();
    check("ldb valid", bus.mem_to_wb_valid, 1);
    check("ldb wdata", bus.mem_rf_wdata, 32'hFFFF_FF80);
    check("ldb stall off", bus.mem_fwd_stall, 0);
    cyc_start(); set_idle(); sample();
    check("ldb single", bus.mem_to_wb_valid, 0);

    // Response under WB back-pressure must be buffered and delivered once.
    cyc_start(); set_idle();
    present(LD_W, 32'h0000_5000, 1'b1, 1'b0, 1'b1, 5'd9, 32'h1C00_2000);
    sample();
    cyc_start(); set_idle();
    bus.wb_allowin        = 1'b0;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h1357_9BDF;
    sample();
    check("bp valid", bus.mem_to_wb_valid, 1);
    check("bp allowin", bus.mem_allowin, 0);
    repeat (2) begin
      cyc_start(); set_idle();
      bus.wb_allowin = 1'b0;
      sample();
      check("bp held valid", bus.mem_to_wb_valid, 1);
      check("bp buffered", bus.mem_rf_wdata, 32'h1357_9BDF);
      check("bp no stall", bus.mem_fwd_stall, 0);
    end
    cyc_start(); set_idle(); sample();
    check("bp release", bus.mem_rf_wdata, 32'h1357_9BDF);
    check("bp release valid", bus.mem_to_wb_valid, 1);
    cyc_start(); set_idle(); sample();
    check("bp no dup", bus.mem_to_wb_valid, 0);

    // Flush while a load waits and EX presents a sent store: two stale responses.
    cyc_start(); set_idle();
    present(LD_W, 32'h0000_6000, 1'b1, 1'b0, 1'b1, 5'd3, 32'h1C00_3000);
    sample();
    cyc_start(); set_idle();
    bus.flush = 1'b1;
    present(5'd0, 32'h0000_6100, 1'b1, 1'b0, 1'b0, 5'd0, 32'h1C00_3004);
    sample();
    check("fl valid", bus.mem_to_wb_valid, 0);
    check("fl stall", bus.mem_fwd_stall, 1);
    cyc_start(); set_idle();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hBAD0_0001;
    present(LD_HU, 32'h0000_6202, 1'b1, 1'b0, 1'b1, 5'd4, 32'h1C00_3008);
    sample();
    check("fl allowin", bus.mem_allowin, 1);
    cyc_start(); set_idle();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'hBAD0_0002;
    sample();
    check("fl stale2 stall", bus.mem_fwd_stall, 1);
    check("fl stale2 valid", bus.mem_to_wb_valid, 0);
    cyc_start(); set_idle();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h1234_5678;
    sample();
    check("fl own valid", bus.mem_to_wb_valid, 1);
    check("fl own wdata", bus.mem_rf_wdata, 32'h0000_1234);
    cyc_start(); set_idle(); sample();
    check("fl drained", bus.mem_to_wb_valid, 0);

    // Exception instruction: no request, immediate ready, never forwarded.
    cyc_start(); set_idle();
    present(5'd0, 32'h0000_7000, 1'b0, 1'b1, 1'b1, 5'd5, 32'h1C00_4000);
    sample();
    cyc_start(); set_idle();
    bus.wb_allowin = 1'b0;
    sample();
    check("ex active", bus.mem_excep_active, 1);
    check("ex excep", bus.mem_excep, 1);
    check("ex fwd_we", bus.mem_fwd_we, 0);
    check("ex valid", bus.mem_to_wb_valid, 1);
    cyc_start(); set_idle(); sample();
    check("ex active held", bus.mem_excep_active, 1);
    cyc_start(); set_idle(); sample();
    check("ex gone", bus.mem_excep_active, 0);

    // Async reset mid-wait, with a stale response pending in the cancel counter.
    cyc_start(); set_idle();
    present(LD_B, 32'h0000_8000, 1'b1, 1'b0, 1'b1, 5'd6, 32'h1C00_5000);
    sample();
    cyc_start(); set_idle();
    bus.flush = 1'b1;
    sample();
    cyc_start(); set_idle();
    present(LD_W, 32'h0000_8100, 1'b1, 1'b0, 1'b1, 5'd8, 32'h1C00_5004);
    sample();
    cyc_start(); set_idle();
    #1 resetn = 1'b0;
    #1 check_reset("midreset");
    @(posedge clk);
    #1 resetn = 1'b1;
    cyc_start(); set_idle();
    present(LD_BU, 32'h0000_8201, 1'b1, 1'b0, 1'b1, 5'd10, 32'h1C00_5008);
    sample();
    cyc_start(); set_idle();
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h0000_AB00;
    sample();
    check("rst cancel cleared", bus.mem_to_wb_valid, 1);
    check("rst wdata", bus.mem_rf_wdata, 32'h0000_00AB);
    cyc_start(); set_idle(); sample();

    // Random traffic: responses in order, owned by instruction id; stale ones belong to no one.
    occ = '{v: 1'b0, id: 0, pc: 32'd0, op: 5'd0, addr: 32'd0, needs: 1'b0,
            rcvd: 1'b0, data: 32'd0, excep: 1'b0, we: 1'b0};
    nid = 1;
    for (int c = 0; c < 3000; c++) begin
      cyc_start(); set_idle();
      bus.wb_allowin = ($urandom_range(0, 3) != 0);
      deliver = 1'b0;
      d_id    = 0;
      if (rq.size() > 0 && rq[0].issued < c && $urandom_range(0, 2) != 0) begin
        deliver = 1'b1;
        d_id    = rq[0].id;
      end
      bus.data_sram_data_ok = deliver;
      stale = 0;
      foreach (rq[k]) if (!(occ.v && rq[k].id == occ.id)) stale++;
      bus.flush = (stale <= 1) && ($urandom_range(0, 19) == 0);

      hit       = deliver && occ.v && (d_id == occ.id);
      have      = occ.rcvd || hit;
      e_ready   = !occ.needs || have;
      e_valid   = occ.v && e_ready && !bus.flush;
      e_allowin = !occ.v || (e_ready && bus.wb_allowin);
      e_stall   = occ.v && (occ.op != 5'd0) && !have;
      word      = occ.rcvd ? occ.data : bus.data_sram_rdata;
      e_wdata   = ref_wdata(occ.op, occ.addr, word);

      pres = e_allowin && ($urandom_range(0, 1) == 1);
      if (pres) begin
        kind     = $urandom_range(0, 9);
        nw.v     = 1'b1;
        nw.id    = nid;
        nw.pc    = 32'h1C10_0000 + 32'(4 * c);
        nw.op    = (kind <= 4) ? 5'(1 << kind) : 5'd0;
        nw.addr  = $urandom();
        nw.needs = (kind <= 5);
        nw.rcvd  = 1'b0;
        nw.data  = 32'd0;
        nw.excep = (kind == 6);
        nw.we    = (kind != 5) && ($urandom_range(0, 3) != 0);
        nid++;
        present(nw.op, nw.addr, nw.needs, nw.excep, nw.we, 5'($urandom_range(1, 31)), nw.pc);
      end
      sample();

      check("rnd to_wb_valid", bus.mem_to_wb_valid, e_valid);
      check("rnd allowin", bus.mem_allowin, e_allowin);
      check("rnd fwd_stall", bus.mem_fwd_stall, e_stall);
      check("rnd excep_active", bus.mem_excep_active, occ.v && occ.excep);
      check("rnd fwd_we", bus.mem_fwd_we, occ.v && occ.we && !occ.excep);
      if (e_valid) begin
        check("rnd pc", bus.mem_pc, occ.pc);
        if (!occ.excep) check("rnd wdata", bus.mem_rf_wdata, e_wdata);
      end

      if (deliver) void'(rq.pop_front());
      if (pres && nw.needs) begin
        rtmp.id     = nw.id;
        rtmp.issued = c;
        rq.push_back(rtmp);
      end
      if (bus.flush) begin
        occ.v = 1'b0;
      end else begin
        if (occ.v && e_ready && bus.wb_allowin) begin
          occ.v = 1'b0;
        end else if (hit) begin
          occ.rcvd = 1'b1;
          occ.data = bus.data_sram_rdata;
        end
        if (pres) occ = nw;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
